// File: rtl/hwpe_stream_fifo_thr.sv
// Stream FIFO with occupancy count and programmable almost-full/almost-empty
// thresholds. Storage is a flip-flop array of {strb, data} words addressed by
// push/pop pointers that wrap at FIFO_DEPTH-1, so any depth >= 2 works.
//
// Handshake: a word moves on a stream when valid & ready are both 1 at a
// rising edge. A source never lowers valid or changes data/strb before that
// handshake, and the FIFO's push ready never depends on pop ready.
//
// With FALL_THROUGH=1 an empty FIFO presents the incoming push word on the
// pop side in the same cycle; if it is consumed immediately it never touches
// storage, otherwise it is stored and re-presented from storage next cycle.
module hwpe_stream_fifo_thr #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter bit          FALL_THROUGH = 1'b0,
  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
  localparam int unsigned CNT_WIDTH   = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned ADDR_WIDTH  = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [CNT_WIDTH-1:0]  almost_full_thr_i,
  input  logic [CNT_WIDTH-1:0]  almost_empty_thr_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  // {empty, full, almost_empty, almost_full}
  output logic [3:0]            flags_o,
  // push stream (sink)
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [STRB_WIDTH-1:0] push_strb_i,
  // pop stream (source)
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [STRB_WIDTH-1:0] pop_strb_o
);

  localparam int unsigned WORD_WIDTH = DATA_WIDTH + STRB_WIDTH;
  localparam logic [CNT_WIDTH-1:0]  DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(FIFO_DEPTH - 1);

  logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push_ready;
  logic                  w_pop_valid;
  logic                  w_push_hs;
  logic                  w_pop_hs;
  logic                  w_bypass;
  logic                  w_write;
  logic                  w_read;
  logic [WORD_WIDTH-1:0] w_push_word;
  logic [WORD_WIDTH-1:0] w_pop_word;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == DEPTH_C);
  assign w_push_word = {push_strb_i, push_data_i};

  // Ready/valid generation; clear blocks both sides so no handshake happens
  always_comb begin
    w_push_ready = (r_count < DEPTH_C) && !clear_i;
    w_pop_valid  = 1'b0;
    if (!clear_i) begin
      if (!w_empty) begin
        w_pop_valid = 1'b1;
      end else if (FALL_THROUGH) begin
        w_pop_valid = push_valid_i;
      end
    end
  end

  assign w_push_hs = push_valid_i & w_push_ready;
  assign w_pop_hs  = w_pop_valid & pop_ready_i;
  // An empty FIFO can only complete a pop via fall-through: that is the bypass.
  assign w_bypass  = w_pop_hs & w_empty;
  assign w_write   = w_push_hs & ~w_bypass;
  assign w_read    = w_pop_hs & ~w_bypass;

  // Output word: head of storage, or the live push word when bypassing an empty FIFO
  always_comb begin
    w_pop_word = w_empty ? w_push_word : r_mem[r_rd_ptr];
    if (!w_pop_valid) begin
      w_pop_word = '0;
    end
  end

  assign push_ready_o = w_push_ready;
  assign pop_valid_o  = w_pop_valid;
  assign pop_data_o   = w_pop_word[DATA_WIDTH-1:0];
  assign pop_strb_o   = w_pop_word[WORD_WIDTH-1:DATA_WIDTH];
  assign count_o      = r_count;
  assign flags_o      = {w_empty, w_full,
                         (r_count <= almost_empty_thr_i),
                         (r_count >= almost_full_thr_i)};

  // Storage write; contents are not reset, only pointers and count are
  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_push_word;
    end
  end

  // Pointer and occupancy update; reset beats clear beats normal operation
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_read) begin
        r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_write && !w_read) begin
        r_count <= r_count + 1'b1;
      end else if (w_read && !w_write) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hwpe_stream_fifo_thr.sv
// Bench for hwpe_stream_fifo_thr: a depth-5 registered FIFO driven from a
// vector table, and a depth-5 fall-through FIFO driven by a short sequence.
module tb_hwpe_stream_fifo_thr;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // registered instance
  logic          a_clear, a_pv, a_pr, a_ready, a_valid;
  logic [DW-1:0] a_pd, a_data;
  logic [SW-1:0] a_ps, a_strb;
  logic [CW-1:0] a_af, a_ae, a_count;
  logic [3:0]    a_flags;

  // fall-through instance
  logic          f_clear, f_pv, f_pr, f_ready, f_valid;
  logic [DW-1:0] f_pd, f_data;
  logic [SW-1:0] f_ps, f_strb;
  logic [CW-1:0] f_af, f_ae, f_count;
  logic [3:0]    f_flags;

  hwpe_stream_fifo_thr #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FALL_THROUGH(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear),
    .almost_full_thr_i(a_af), .almost_empty_thr_i(a_ae),
    .count_o(a_count), .flags_o(a_flags),
    .push_valid_i(a_pv), .push_ready_o(a_ready), .push_data_i(a_pd), .push_strb_i(a_ps),
    .pop_valid_o(a_valid), .pop_ready_i(a_pr), .pop_data_o(a_data), .pop_strb_o(a_strb)
  );

  hwpe_stream_fifo_thr #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FALL_THROUGH(1'b1)) u_dut_ft (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(f_clear),
    .almost_full_thr_i(f_af), .almost_empty_thr_i(f_ae),
    .count_o(f_count), .flags_o(f_flags),
    .push_valid_i(f_pv), .push_ready_o(f_ready), .push_data_i(f_pd), .push_strb_i(f_ps),
    .pop_valid_o(f_valid), .pop_ready_i(f_pr), .pop_data_o(f_data), .pop_strb_o(f_strb)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] strb_of(input logic [DW-1:0] d);
    return d[SW-1:0] ^ 4'hA;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst_n;
    logic          clear;
    logic          pv;
    logic [DW-1:0] pd;
    logic          pr;
    logic [CW-1:0] af;
    logic [CW-1:0] ae;
    logic          exp_ready;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_count;
    logic [3:0]    exp_flags;
  } vec_t;

  vec_t vecs[$];
  logic [CW-1:0] tbl_af = 3'd4;
  logic [CW-1:0] tbl_ae = 3'd1;

  // Flag encodings {empty, full, ae, af} for af=4, ae=1
  localparam logic [3:0] F0 = 4'b1010;
  localparam logic [3:0] F1 = 4'b0010;
  localparam logic [3:0] F2 = 4'b0000;
  localparam logic [3:0] F3 = 4'b0000;
  localparam logic [3:0] F4 = 4'b0001;
  localparam logic [3:0] F5 = 4'b0101;

  function automatic void add(input logic rn, input logic cl, input logic pv,
                              input logic [DW-1:0] pd, input logic pr,
                              input logic er, input logic ev, input logic [DW-1:0] ed,
                              input logic [CW-1:0] ec, input logic [3:0] ef);
    vec_t v;
    v.rst_n = rn; v.clear = cl; v.pv = pv; v.pd = pd; v.pr = pr;
    v.af = tbl_af; v.ae = tbl_ae;
    v.exp_ready = er; v.exp_valid = ev; v.exp_data = ed;
    v.exp_count = ec; v.exp_flags = ef;
    vecs.push_back(v);
  endfunction

  // ---------------- driver ----------------
  // Each row: drive inputs, compare combinational outputs against the
  // pre-edge state, then take the clock edge.
  task automatic apply_row(input int i, input vec_t v);
    rst_n   = v.rst_n;
    a_clear = v.clear;
    a_pv    = v.pv;
    a_pd    = v.pd;
    a_ps    = strb_of(v.pd);
    a_pr    = v.pr;
    a_af    = v.af;
    a_ae    = v.ae;
    #1;
    check($sformatf("v%0d.ready", i), DW'(a_ready), DW'(v.exp_ready));
    check($sformatf("v%0d.valid", i), DW'(a_valid), DW'(v.exp_valid));
    check($sformatf("v%0d.data", i),  a_data, v.exp_data);
    check($sformatf("v%0d.strb", i),  DW'(a_strb),
          v.exp_valid ? DW'(strb_of(v.exp_data)) : '0);
    check($sformatf("v%0d.count", i), DW'(a_count), DW'(v.exp_count));
    check($sformatf("v%0d.flags", i), DW'(a_flags), DW'(v.exp_flags));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] exp_pop;

    rst_n = 1'b0;
    a_clear = 0; a_pv = 0; a_pd = '0; a_ps = '0; a_pr = 0; a_af = 3'd4; a_ae = 3'd1;
    f_clear = 0; f_pv = 0; f_pd = '0; f_ps = '0; f_pr = 0; f_af = 3'd4; f_ae = 3'd1;

    // ---- table: rst, clr, pv, pd, pr | ready, valid, data, count, flags ----
    add(1, 0, 0, 32'h0, 0,   1, 0, 32'h0, 0, F0);          // reset state
    // fill with 7 pushes while pop is stalled: only 1..5 accepted
    add(1, 0, 1, 32'h1, 0,   1, 0, 32'h0, 0, F0);
    add(1, 0, 1, 32'h2, 0,   1, 1, 32'h1, 1, F1);
    add(1, 0, 1, 32'h3, 0,   1, 1, 32'h1, 2, F2);
    add(1, 0, 1, 32'h4, 0,   1, 1, 32'h1, 3, F3);
    add(1, 0, 1, 32'h5, 0,   1, 1, 32'h1, 4, F4);
    add(1, 0, 1, 32'h6, 0,   0, 1, 32'h1, 5, F5);
    add(1, 0, 1, 32'h7, 0,   0, 1, 32'h1, 5, F5);
    // full with simultaneous pop: push still refused
    add(1, 0, 1, 32'h8, 1,   0, 1, 32'h1, 5, F5);
    add(1, 0, 0, 32'h0, 1,   1, 1, 32'h2, 4, F4);
    add(1, 0, 0, 32'h0, 1,   1, 1, 32'h3, 3, F3);
    // 12 push+pop handshakes at count 2 (holds 4,5), wrapping pointers twice
    for (int k = 0; k < 12; k++) begin
      exp_pop = (k == 0) ? 32'h4 : (k == 1) ? 32'h5 : 32'h10 + DW'(k - 2);
      add(1, 0, 1, 32'h10 + DW'(k), 1,   1, 1, exp_pop, 2, F2);
    end
    add(1, 0, 0, 32'h0, 1,   1, 1, 32'h1A, 2, F2);
    add(1, 0, 0, 32'h0, 1,   1, 1, 32'h1B, 1, F1);
    add(1, 0, 0, 32'h0, 1,   1, 0, 32'h0,  0, F0);
    // fill 3, then clear with a push offered
    add(1, 0, 1, 32'h21, 0,  1, 0, 32'h0,  0, F0);
    add(1, 0, 1, 32'h22, 0,  1, 1, 32'h21, 1, F1);
    add(1, 0, 1, 32'h23, 0,  1, 1, 32'h21, 2, F2);
    add(1, 1, 1, 32'h24, 1,  0, 0, 32'h0,  3, F3);
    add(1, 0, 0, 32'h0, 1,   1, 0, 32'h0,  0, F0);
    // fill 4, then reset mid-operation with a push offered
    add(1, 0, 1, 32'h31, 0,  1, 0, 32'h0,  0, F0);
    add(1, 0, 1, 32'h32, 0,  1, 1, 32'h31, 1, F1);
    add(1, 0, 1, 32'h33, 0,  1, 1, 32'h31, 2, F2);
    add(1, 0, 1, 32'h34, 0,  1, 1, 32'h31, 3, F3);
    add(0, 0, 1, 32'h35, 0,  1, 1, 32'h31, 4, F4);
    add(1, 0, 0, 32'h0, 0,   1, 0, 32'h0,  0, F0);
    add(1, 0, 1, 32'h55, 0,  1, 0, 32'h0,  0, F0);
    // thresholds changed live: af=1 -> set at count 1, ae=0 -> clear at count 1
    tbl_af = 3'd1; tbl_ae = 3'd0;
    add(1, 0, 0, 32'h0, 0,   1, 1, 32'h55, 1, 4'b0001);
    tbl_af = 3'd4; tbl_ae = 3'd1;
    add(1, 0, 0, 32'h0, 1,   1, 1, 32'h55, 1, F1);
    add(1, 0, 0, 32'h0, 0,   1, 0, 32'h0,  0, F0);

    // ---- reset both instances ----
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) apply_row(i, vecs[i]);

    // ---- fall-through: bypass with pop ready ----
    f_pv = 1; f_pd = 32'hAA; f_ps = strb_of(32'hAA); f_pr = 1;
    #1;
    check("ft.bypass.valid", DW'(f_valid), 32'd1);
    check("ft.bypass.data",  f_data, 32'hAA);
    check("ft.bypass.strb",  DW'(f_strb), DW'(strb_of(32'hAA)));
    check("ft.bypass.ready", DW'(f_ready), 32'd1);
    @(posedge clk); #1;
    f_pv = 0; f_pd = '0; f_ps = '0;
    #1;
    check("ft.bypass.count", DW'(f_count), 32'd0);
    check("ft.bypass.after_valid", DW'(f_valid), 32'd0);
    check("ft.bypass.after_data",  f_data, 32'd0);

    // ---- fall-through: pop stalled, word is stored ----
    f_pv = 1; f_pd = 32'hBB; f_ps = strb_of(32'hBB); f_pr = 0;
    #1;
    check("ft.stall.valid", DW'(f_valid), 32'd1);
    check("ft.stall.data",  f_data, 32'hBB);
    @(posedge clk); #1;
    f_pv = 0; f_pd = '0; f_ps = '0;
    #1;
    check("ft.stall.count", DW'(f_count), 32'd1);
    check("ft.stall.held_valid", DW'(f_valid), 32'd1);
    check("ft.stall.held_data",  f_data, 32'hBB);
    check("ft.stall.flags", DW'(f_flags), DW'(F1));
    f_pr = 1;
    @(posedge clk); #1;
    f_pr = 0;
    #1;
    check("ft.drain.count", DW'(f_count), 32'd0);
    check("ft.drain.valid", DW'(f_valid), 32'd0);

    // ---- report ----
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
